// File: rtl/sudoku_grid_loader.sv
// sudoku_grid_loader
//   Feeds the sudoku solver core. Takes one 4-bit digit per cell over a
//   valid/ready stream and expands it into a 9-bit candidate mask. It packs
//   81 masks into the 729-bit grid, pulses start, and then holds the grid
//   until the solver reports done.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   clr          synchronous abort; drops the partial or held puzzle
//   in_valid     in_digit valid
//   in_ready     loader can take a digit (LOAD state only)
//   in_digit     0 = unknown, 1..9 = given digit, 10..15 = illegal
//   solver_done  solver finished; returns WAIT -> LOAD
//   grid         assembled grid; cell i at bits [9i+8:9i]
//   start        one-cycle launch pulse
//   busy         high in LAUNCH and WAIT
//   fmt_error    sticky flag for an accepted illegal digit
//   cell_idx     number of cells accepted in the current puzzle
//   given_count  (GIVEN_COUNT_EN only) number of accepted digits 1..9
//
// Optional feature macro: GIVEN_COUNT_EN
module sudoku_grid_loader #(
    parameter int CELLS  = 81,
    parameter int CELL_W = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_digit,
    input  logic                    solver_done,
    output logic [CELLS*CELL_W-1:0] grid,
    output logic                    start,
    output logic                    busy,
    output logic                    fmt_error,
    output logic [6:0]              cell_idx
`ifdef GIVEN_COUNT_EN
    ,
    output logic [6:0]              given_count
`endif
);

    typedef enum logic [1:0] {LOAD, LAUNCH, WAIT} state_t;

    state_t state_q, state_d;

    logic [CELLS-1:0][CELL_W-1:0] cells_q;
    logic [CELL_W-1:0]            mask;
    logic                         accept;
    logic                         last;
    logic                         is_given;
    logic                         solve_end;

    assign in_ready  = (state_q == LOAD) && !reset && !clr;
    assign accept    = in_valid && in_ready;
    assign last      = (cell_idx == 7'(CELLS - 1));
    assign is_given  = (in_digit != 4'd0) && (in_digit <= 4'd9);
    assign solve_end = (state_q == WAIT) && solver_done;
    assign busy      = (state_q != LOAD);
    assign grid      = cells_q;

    // Unknown and illegal digits both mean "any candidate"; a given digit
    // leaves a single candidate bit.
    always_comb begin
        mask = '1;
        if (is_given)
            mask = CELL_W'(1) << (in_digit - 4'd1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept && last) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;   // done seen here is ignored
            WAIT:    if (solver_done) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_q   <= LOAD;
            cells_q   <= '0;
            cell_idx  <= '0;
            start     <= 1'b0;
            fmt_error <= 1'b0;
        end else begin
            state_q <= state_d;
            // start is high in the LAUNCH cycle, right after the last accept
            start   <= accept && last;
            if (accept) begin
                for (int c = 0; c < CELLS; c++)
                    if (cell_idx == 7'(c))
                        cells_q[c] <= mask;
                cell_idx <= cell_idx + 7'd1;
                if (in_digit > 4'd9)
                    fmt_error <= 1'b1;
            end
            // Grid is kept on return to LOAD; it is overwritten cell by cell.
            if (solve_end)
                cell_idx <= '0;
        end
    end

`ifdef GIVEN_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || clr || solve_end)
            given_count <= '0;
        else if (accept && is_given && given_count != 7'(CELLS))
            given_count <= given_count + 7'd1;
    end
`endif

endmodule

// File: tb/tb_sudoku_grid_loader.sv
module tb_sudoku_grid_loader;

    localparam int N = 81;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           clr = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     in_digit = 4'd0;
    logic           solver_done = 1'b0;
    logic [728:0]   grid;
    logic           start;
    logic           busy;
    logic           fmt_error;
    logic [6:0]     cell_idx;
`ifdef GIVEN_COUNT_EN
    logic [6:0]     given_count;
`endif

    sudoku_grid_loader dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_digit    (in_digit),
        .solver_done (solver_done),
        .grid        (grid),
        .start       (start),
        .busy        (busy),
        .fmt_error   (fmt_error),
        .cell_idx    (cell_idx)
`ifdef GIVEN_COUNT_EN
        ,
        .given_count (given_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [8:0] m;
    } sb_t;

    sb_t        sbq[$];
    logic [3:0] dig[N];
    int         total = 0;
    int         bad = 0;
    int         exp_idx = 0;
    logic       exp_fmt = 1'b0;
    int         start_cnt = 0;

    always @(negedge clk) if (start) start_cnt++;

    function automatic logic [8:0] exp_mask(input logic [3:0] d);
        if (d == 4'd0 || d > 4'd9) return 9'h1FF;
        return 9'h001 << (d - 1);
    endfunction

    // Drive n digits from dig[], gap = percent chance of idling a cycle.
    // Expected masks go to the scoreboard on accept and are checked against
    // the grid once the load stops.
    task automatic load(input int n, input int gap, input bit done_in_launch);
        int  i = 0;
        int  cyc = 0;
        bit  acc;
        sb_t e;
        while (i < n && cyc < 2000) begin
            @(negedge clk);
            in_valid = ($urandom_range(99) >= gap);
            in_digit = dig[i];
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_ready cell=%0d got=%b want=1", i, in_ready);
            end
            acc = in_valid;
            if (acc) begin
                e.idx = exp_idx;
                e.m   = exp_mask(dig[i]);
                sbq.push_back(e);
                if (dig[i] > 4'd9) exp_fmt = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                exp_idx++;
                i++;
            end
            total++;
            if (cell_idx !== 7'(exp_idx)) begin
                bad++;
                $display("FAIL load_idx got=%0d want=%0d", cell_idx, exp_idx);
            end
            total++;
            if (start !== (acc && exp_idx == N)) begin
                bad++;
                $display("FAIL load_start got=%b want=%b idx=%0d", start, acc && exp_idx == N, exp_idx);
            end
        end
        in_valid = 1'b0;
        total++;
        if (i != n) begin
            bad++;
            $display("FAIL load_timeout accepted=%0d want=%0d", i, n);
        end
        total++;
        if (gap == 0 && cyc != n) begin
            bad++;
            $display("FAIL load_rate cycles=%0d want=%0d", cyc, n);
        end
        if (n == N) begin
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL launch_busy got=%b want=1", busy);
            end
            if (done_in_launch) solver_done = 1'b1;
            @(posedge clk);
            #1;
            solver_done = 1'b0;
            total++;
            if ({busy, start, in_ready, cell_idx} !== {1'b1, 1'b0, 1'b0, 7'd81}) begin
                bad++;
                $display("FAIL wait_entry busy/start/rdy/idx got=%b%b%b/%0d want=100/81",
                         busy, start, in_ready, cell_idx);
            end
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            total++;
            if (grid[e.idx*9 +: 9] !== e.m) begin
                bad++;
                $display("FAIL cell_mask cell=%0d got=%h want=%h", e.idx, grid[e.idx*9 +: 9], e.m);
            end
        end
        total++;
        if (fmt_error !== exp_fmt) begin
            bad++;
            $display("FAIL fmt_after_load got=%b want=%b", fmt_error, exp_fmt);
        end
    endtask

    task automatic finish_solve();
        logic [728:0] held;
        held = grid;
        @(negedge clk);
        solver_done = 1'b1;
        @(posedge clk);
        #1;
        solver_done = 1'b0;
        exp_idx = 0;
        total++;
        if ({busy, in_ready, cell_idx} !== {1'b0, 1'b1, 7'd0}) begin
            bad++;
            $display("FAIL done_return busy/rdy/idx got=%b%b/%0d want=01/0", busy, in_ready, cell_idx);
        end
        total++;
        if (grid !== held) begin
            bad++;
            $display("FAIL done_grid_retained got=%h want=%h", grid, held);
        end
`ifdef GIVEN_COUNT_EN
        total++;
        if (given_count !== 7'd0) begin
            bad++;
            $display("FAIL done_given_clear got=%0d want=0", given_count);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, start, busy, fmt_error, cell_idx} !== 11'd0 || grid !== '0) begin
            bad++;
            $display("FAIL reset_state rdy/start/busy/fmt/idx got=%b%b%b%b/%0d grid_nz=%b want=0",
                     in_ready, start, busy, fmt_error, cell_idx, |grid);
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        exp_idx = 0;
        exp_fmt = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_all_unknown();
        int s0;
        for (int i = 0; i < N; i++) dig[i] = 4'd0;
        s0 = start_cnt;
        load(N, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (grid !== {729{1'b1}}) begin
            bad++;
            $display("FAIL unknown_grid got=%h want=all ones", grid);
        end
        total++;
        if (start_cnt - s0 != 1) begin
            bad++;
            $display("FAIL unknown_start_count got=%0d want=1", start_cnt - s0);
        end
        finish_solve();
    endtask

    task automatic test_digits();
        logic [728:0] held;
        for (int i = 0; i < N; i++) dig[i] = 4'((i % 9) + 1);
        load(N, 0, 1'b1);  // done during LAUNCH must be ignored
        total++;
        if ({grid[8:0], grid[80:72], grid[728:720]} !== {9'h001, 9'h100, 9'h100}) begin
            bad++;
            $display("FAIL digits_cells c0/c8/c80 got=%h/%h/%h want=001/100/100",
                     grid[8:0], grid[80:72], grid[728:720]);
        end
        held = grid;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_digit = 4'd4;
            #1;
            total++;
            if (in_ready !== 1'b0 || grid !== held || busy !== 1'b1) begin
                bad++;
                $display("FAIL wait_hold cyc=%0d rdy=%b busy=%b grid_changed=%b", k, in_ready, busy, grid !== held);
            end
        end
        in_valid = 1'b0;
        finish_solve();
    endtask

    task automatic test_random_gaps();
        for (int i = 0; i < N; i++) dig[i] = 4'($urandom_range(9));
        load(N, 50, 1'b0);
        finish_solve();
    endtask

    task automatic test_fmt_error();
        for (int i = 0; i < N; i++) dig[i] = 4'($urandom_range(9, 1));
        dig[5] = 4'd12;
        load(N, 0, 1'b0);
        total++;
        if (grid[53:45] !== 9'h1FF || fmt_error !== 1'b1) begin
            bad++;
            $display("FAIL fmt_cell5 got=%h fmt=%b want=1ff fmt=1", grid[53:45], fmt_error);
        end
        finish_solve();
        total++;
        if (fmt_error !== 1'b1) begin
            bad++;
            $display("FAIL fmt_sticky_load got=%b want=1", fmt_error);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_fmt = 1'b0;
        exp_idx = 0;
        total++;
        if (fmt_error !== 1'b0 || grid !== '0) begin
            bad++;
            $display("FAIL fmt_clr got=%b grid_nz=%b want=0/0", fmt_error, |grid);
        end
    endtask

    task automatic test_clr_midload();
        int s0;
        for (int i = 0; i < N; i++) dig[i] = 4'($urandom_range(9, 1));
        s0 = start_cnt;
        load(40, 0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        in_valid = 1'b1;
        in_digit = 4'd3;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_ready got=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (cell_idx !== 7'd0 || grid !== '0 || busy !== 1'b0 || start !== 1'b0) begin
            bad++;
            $display("FAIL clr_state idx=%0d grid_nz=%b busy=%b start=%b want=0", cell_idx, |grid, busy, start);
        end
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        exp_idx = 0;
        exp_fmt = 1'b0;
        total++;
        if (start_cnt != s0) begin
            bad++;
            $display("FAIL clr_no_start got=%0d want=0", start_cnt - s0);
        end
        for (int i = 0; i < N; i++) dig[i] = 4'($urandom_range(9));
        load(N, 20, 1'b0);
        finish_solve();
    endtask

`ifdef GIVEN_COUNT_EN
    task automatic test_given_count();
        for (int i = 0; i < N; i++) dig[i] = (i < 30) ? 4'((i % 9) + 1) : 4'd0;
        load(N, 0, 1'b0);
        total++;
        if (given_count !== 7'd30) begin
            bad++;
            $display("FAIL given_count got=%0d want=30", given_count);
        end
        finish_solve();
    endtask
`endif

    initial begin
        test_reset();
        test_all_unknown();
        test_digits();
        test_random_gaps();
        test_fmt_error();
        test_clr_midload();
`ifdef GIVEN_COUNT_EN
        test_given_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
